// File: rtl/a2d_edge_if.sv
// Bundle for the analog-sample input side and the edge-event output side of
// the receiver. The master modport is the solver/consumer side, slave is the receiver.
interface a2d_edge_if #(
  parameter int CODE_W = 12,
  parameter int TS_W   = 16
);
  logic              sample_valid;
  logic [CODE_W-1:0] sample_code;
  logic              dout;
  logic              rise_pulse;
  logic              fall_pulse;
  logic              evt_valid;
  logic              evt_ready;
  logic              evt_pol;
  logic [TS_W-1:0]   evt_ts;
  logic              evt_ovf;

  modport master (
    output sample_valid, sample_code, evt_ready,
    input  dout, rise_pulse, fall_pulse, evt_valid, evt_pol, evt_ts, evt_ovf
  );

  modport slave (
    input  sample_valid, sample_code, evt_ready,
    output dout, rise_pulse, fall_pulse, evt_valid, evt_pol, evt_ts, evt_ovf
  );
endinterface

// File: rtl/a2d_edge_receiver.sv
// Turns quantized analog samples into a debounced digital level via a hysteresis
// comparator, and queues every committed edge with its timestamp in a show-ahead FIFO.
module a2d_edge_receiver #(
  parameter int CODE_W     = 12,
  parameter int VTH_HI     = 2458,
  parameter int VTH_LO     = 1638,
  parameter int DEBOUNCE   = 3,
  parameter bit INIT_LEVEL = 1'b0,
  parameter int TS_W       = 16,
  parameter int EVT_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  a2d_edge_if.slave  bus
);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = $clog2(EVT_DEPTH);
  localparam logic [CODE_W-1:0] TH_HI   = CODE_W'(VTH_HI);
  localparam logic [CODE_W-1:0] TH_LO   = CODE_W'(VTH_LO);
  localparam logic [CNT_W-1:0]  DB_C    = CNT_W'(DEBOUNCE);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(EVT_DEPTH);

  typedef enum logic [1:0] {LO_STABLE, HI_ARM, HI_STABLE, LO_ARM} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
  logic              commit_rise, commit_fall;
  logic              qh, ql, arm_done;
  logic              dout_q, rise_q, fall_q;
  logic [TS_W-1:0]   ts, ts_next;

  assign qh       = bus.sample_code >= TH_HI;
  assign ql       = bus.sample_code <= TH_LO;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign arm_done = (cnt_inc == DB_C);
  assign ts_next  = ts + TS_W'(1);

  // Any valid sample that breaks a run while arming drops back to the held level.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    if (bus.sample_valid) begin
      case (state)
        LO_STABLE: if (qh) begin
          if (DEBOUNCE == 1) commit_rise = 1'b1;
          else begin
            cnt_next   = CNT_W'(1);
            state_next = HI_ARM;
          end
        end
        HI_ARM: if (qh) begin
          if (arm_done) commit_rise = 1'b1;
          else          cnt_next    = cnt_inc;
        end else begin
          cnt_next   = '0;
          state_next = LO_STABLE;
        end
        HI_STABLE: if (ql) begin
          if (DEBOUNCE == 1) commit_fall = 1'b1;
          else begin
            cnt_next   = CNT_W'(1);
            state_next = LO_ARM;
          end
        end
        LO_ARM: if (ql) begin
          if (arm_done) commit_fall = 1'b1;
          else          cnt_next    = cnt_inc;
        end else begin
          cnt_next   = '0;
          state_next = HI_STABLE;
        end
        default: state_next = state;
      endcase
    end
    if (commit_rise) begin
      state_next = HI_STABLE;
      cnt_next   = '0;
    end
    if (commit_fall) begin
      state_next = LO_STABLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INIT_LEVEL ? HI_STABLE : LO_STABLE;
      cnt    <= '0;
      dout_q <= INIT_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      ts     <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      rise_q <= commit_rise;
      fall_q <= commit_fall;
      ts     <= ts_next;
      if (commit_rise)      dout_q <= 1'b1;
      else if (commit_fall) dout_q <= 1'b0;
    end
  end

  logic              mem_pol [EVT_DEPTH];
  logic [TS_W-1:0]   mem_ts  [EVT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [PTR_W:0]    count, count_next;
  logic              push, pop, do_push, full;
  logic              head_pol, ovf_q;
  logic [TS_W-1:0]   head_ts;

  assign push    = commit_rise | commit_fall;
  assign full    = (count == DEPTH_C);
  assign pop     = (count != '0) & bus.evt_ready;
  assign do_push = push & (~full | pop);
  assign rd_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_comb begin
    count_next = count;
    if (do_push && !pop)      count_next = count + (PTR_W + 1)'(1);
    else if (!do_push && pop) count_next = count - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_pol[wr_ptr] <= commit_rise;
      mem_ts[wr_ptr]  <= ts_next;
    end
  end

  // Head registers track the next-cycle head; the slot being written this cycle
  // is not yet in memory, so it is forwarded directly. Empty FIFO holds the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_pol <= 1'b0;
      head_ts  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_next;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (push && full && !pop) ovf_q <= 1'b1;
      if (count_next != '0) begin
        if (do_push && rd_next == wr_ptr) begin
          head_pol <= commit_rise;
          head_ts  <= ts_next;
        end else begin
          head_pol <= mem_pol[rd_next];
          head_ts  <= mem_ts[rd_next];
        end
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.evt_valid  = (count != '0);
  assign bus.evt_pol    = head_pol;
  assign bus.evt_ts     = head_ts;
  assign bus.evt_ovf    = ovf_q;
endmodule

// File: tb/tb_a2d_edge_receiver.sv
// Bench for a2d_edge_receiver: directed scenarios plus random samples, checked by a
// run-length reference model and an event scoreboard popped on every consumer handshake.
module tb_a2d_edge_receiver;
  localparam int CODE_W    = 12;
  localparam int VTH_HI    = 2458;
  localparam int VTH_LO    = 1638;
  localparam int DEBOUNCE  = 3;
  localparam int TS_W      = 16;
  localparam int EVT_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  a2d_edge_if #(.CODE_W(CODE_W), .TS_W(TS_W)) bus ();

  a2d_edge_receiver #(
    .CODE_W(CODE_W), .VTH_HI(VTH_HI), .VTH_LO(VTH_LO), .DEBOUNCE(DEBOUNCE),
    .INIT_LEVEL(1'b0), .TS_W(TS_W), .EVT_DEPTH(EVT_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    bit              pol;
    logic [TS_W-1:0] ts;
  } evt_t;

  evt_t            exp_q[$];
  bit              m_level, m_rise, m_fall, m_ovf;
  int              m_run, m_count;
  logic [TS_W-1:0] m_ts;
  bit              m_pop, m_commit, m_full, m_qual;

  // Reference: the level flips after DEBOUNCE consecutive valid samples on the
  // opposite side of the hysteresis band; any other valid sample restarts the run.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_ovf = 1'b0;
      m_run = 0; m_count = 0; m_ts = '0;
      exp_q.delete();
    end else begin
      m_ts = m_ts + 1'b1;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_commit = 1'b0;
      m_full = (m_count == EVT_DEPTH);
      m_pop = (m_count > 0) && bus.evt_ready;
      if (bus.sample_valid) begin
        m_qual = m_level ? (int'(bus.sample_code) <= VTH_LO) : (int'(bus.sample_code) >= VTH_HI);
        if (m_qual) begin
          m_run++;
          if (m_run == DEBOUNCE) begin
            m_run = 0;
            m_commit = 1'b1;
            m_level = !m_level;
            if (m_level) m_rise = 1'b1;
            else         m_fall = 1'b1;
          end
        end else begin
          m_run = 0;
        end
      end
      if (m_pop) m_count--;
      if (m_commit) begin
        if (m_full && !m_pop) m_ovf = 1'b1;
        else begin
          exp_q.push_back('{pol: m_level, ts: m_ts});
          m_count++;
        end
      end
    end
  end

  evt_t got;
  always @(negedge clk) begin
    check_output("dout", bus.dout, m_level);
    check_output("rise_pulse", bus.rise_pulse, m_rise);
    check_output("fall_pulse", bus.fall_pulse, m_fall);
    check_output("evt_valid", bus.evt_valid, (m_count > 0));
    check_output("evt_ovf", bus.evt_ovf, m_ovf);
    if (bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_evt", 1, 0);
      end else begin
        got = exp_q.pop_front();
        check_output("evt_pol", bus.evt_pol, got.pol);
        check_output("evt_ts", bus.evt_ts, got.ts);
      end
    end
  end

  task automatic apply_stimulus(input bit valid, input int code, input bit ready);
    bus.sample_valid = valid;
    bus.sample_code  = CODE_W'(code);
    bus.evt_ready    = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input int n, input bit valid, input int lo, input int hi, input bit ready);
    for (int i = 0; i < n; i++) apply_stimulus(valid, $urandom_range(hi, lo), ready);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_dout"}, bus.dout, 0);
    check_output({tag, "_evt_valid"}, bus.evt_valid, 0);
    check_output({tag, "_evt_ovf"}, bus.evt_ovf, 0);
    check_output({tag, "_evt_pol"}, bus.evt_pol, 0);
    check_output({tag, "_evt_ts"}, bus.evt_ts, 0);
    check_output({tag, "_pulses"}, {bus.rise_pulse, bus.fall_pulse}, 0);
  endtask

  int side;
  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_code  = '0;
    bus.evt_ready    = 1'b0;
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Rise on third QH sample, stamped at edge 3.
    $display("[TB] directed rise");
    for (int i = 0; i < 3; i++) apply_stimulus(1, 3000, 1);
    drive_n(4, 0, 0, 4095, 1);

    // Band sample in the middle of a falling run restarts it.
    $display("[TB] directed fall with band interruption");
    apply_stimulus(1, 1000, 1);
    apply_stimulus(1, 1000, 1);
    apply_stimulus(1, 2000, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1000, 1);
    drive_n(3, 0, 0, 4095, 1);

    // Band-only oscillation, including both band edges.
    $display("[TB] band oscillation");
    for (int i = 0; i < 50; i++) apply_stimulus(1, (i % 2) ? 2400 : 1700, 1);
    apply_stimulus(1, 2457, 1);
    apply_stimulus(1, 1639, 1);

    // Invalid cycles hold the debounce count; their codes are ignored.
    $display("[TB] invalid cycles hold");
    apply_stimulus(1, 2458, 1);
    apply_stimulus(1, 4095, 1);
    drive_n(10, 0, 0, 1638, 1);
    apply_stimulus(1, 2458, 1);
    drive_n(3, 0, 0, 4095, 1);

    // Back to low at the exact low threshold, then overflow the FIFO.
    $display("[TB] overflow and drain");
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1638, 1);
    drive_n(3, 0, 0, 4095, 1);
    for (int t = 0; t < 5; t++) drive_n(3, 1, (t % 2) ? 0 : 2458, (t % 2) ? 1638 : 4095, 0);
    drive_n(3, 0, 0, 4095, 0);
    check_output("ovf_after_5", bus.evt_ovf, 1);
    drive_n(8, 0, 0, 4095, 1);
    check_output("drained", bus.evt_valid, 0);

    // Reset while arming high with two queued events.
    $display("[TB] reset mid-debounce");
    drive_n(3, 1, 0, 1638, 0);
    drive_n(3, 1, 2458, 4095, 0);
    drive_n(3, 1, 0, 1638, 0);
    apply_stimulus(0, 0, 1);
    apply_stimulus(1, 3000, 0);
    check_output("pre_reset_valid", bus.evt_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(1, 3000, 1);
    drive_n(3, 0, 0, 4095, 1);

    // Random runs with sticky sides and a mostly-stalled consumer.
    $display("[TB] random phase");
    side = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7, 0) == 0) side = $urandom_range(2, 0);
      case (side)
        0:       apply_stimulus($urandom_range(7, 0) != 0, $urandom_range(1638, 0), $urandom_range(9, 0) < 3);
        1:       apply_stimulus($urandom_range(7, 0) != 0, $urandom_range(4095, 2458), $urandom_range(9, 0) < 3);
        default: apply_stimulus($urandom_range(7, 0) != 0, $urandom_range(2457, 1639), $urandom_range(9, 0) < 3);
      endcase
    end
    drive_n(20, 0, 0, 4095, 1);
    check_output("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/a2d_edge_receiver.md
Name: a2d_edge_receiver

Overview:
Receive-side bridge of the mixed-signal co-simulation link. The digital model sends levels toward the analog solver. This block does the reverse: it takes quantized analog node-voltage samples coming back from the solver and converts them into a clean digital level. Conversion uses a hysteresis comparator plus a debounce counter. Each committed transition is queued as a timestamped edge event for consumption by digital logic or the trace monitor.

Parameters:
- CODE_W, 12, width of the quantized voltage code (0 = vss, 2^CODE_W-1 = vdd).
- VTH_HI, 2458, code at or above which a sample qualifies high (about 1.8 V at vdd = 3.0).
- VTH_LO, 1638, code at or below which a sample qualifies low (about 1.2 V); must be less than VTH_HI.
- DEBOUNCE, 3, number of consecutive qualifying valid samples needed to commit a transition; must be 1 or more.
- INIT_LEVEL, 0, digital level and state after reset.
- TS_W, 16, width of the free-running timestamp counter.
- EVT_DEPTH, 4, edge-event FIFO depth; must be a power of 2.

Ports:
- clk, in, 1, sampling clock.
- rst, in, 1, asynchronous active-high reset.
- sample_valid, in, 1, sample_code is valid this cycle.
- sample_code, in, CODE_W, quantized analog node voltage.
- dout, out, 1, debounced digital level.
- rise_pulse, out, 1, one-cycle strobe on a committed 0->1 transition.
- fall_pulse, out, 1, one-cycle strobe on a committed 1->0 transition.
- evt_valid, out, 1, edge FIFO is not empty.
- evt_ready, in, 1, consumer accepts the head event.
- evt_pol, out, 1, head event polarity (1 = rise).
- evt_ts, out, TS_W, head event timestamp.
- evt_ovf, out, 1, sticky flag: an event was dropped.

Behaviour:
- Reset (asynchronous, rst = 1):
  - dout = INIT_LEVEL; state = LO_STABLE if INIT_LEVEL = 0, otherwise HI_STABLE.
  - Debounce count = 0; timestamp = 0.
  - FIFO empty; evt_valid = 0, evt_pol = 0, evt_ts = 0.
  - rise_pulse = fall_pulse = 0; evt_ovf = 0.
- Timestamp: increments by 1 every clk cycle and wraps from 2^TS_W-1 to 0.
- Sample classification, valid cycles only:
  - QH: sample_code >= VTH_HI.
  - QL: sample_code <= VTH_LO.
  - BAND: anything else.
- States: LO_STABLE, HI_ARM, HI_STABLE, LO_ARM.
  - LO_STABLE: a QH sample sets cnt = 1 and moves to HI_ARM. Exception: if DEBOUNCE = 1, the transition commits immediately.
  - HI_ARM: a QH sample increments cnt. A QL or BAND sample sets cnt = 0 and returns to LO_STABLE.
  - HI_STABLE and LO_ARM are symmetric, with QL and QH swapped.
  - Cycles with sample_valid = 0 hold both state and cnt (no timeout).
- Commit:
  - Happens on the clock edge that registers the DEBOUNCE-th consecutive qualifying sample.
  - At that same edge: dout flips, the matching pulse asserts for exactly one cycle, cnt clears, state moves to the new *_STABLE.
  - An event {pol, timestamp value at that edge} is pushed into the FIFO.
  - Latency: dout changes DEBOUNCE valid-sample edges after the first qualifying sample.
- Hysteresis: BAND samples never cause a transition. In a *_STABLE state, samples on the already-held side are ignored.
- FIFO (show-ahead):
  - evt_pol and evt_ts always present the head entry.
  - A pop occurs when evt_valid and evt_ready are both 1.
  - Push and pop in the same cycle is legal, including when the FIFO is full (count unchanged).
  - Push while full with no pop: the new event is dropped, evt_ovf is set, and it stays set until rst.
  - Pointers wrap modulo EVT_DEPTH.
  - While empty, evt_pol and evt_ts hold their last values; consumers must qualify them with evt_valid.
- Reset mid-debounce or mid-FIFO-drain: all state is discarded immediately; no event is emitted for a partial debounce.

Test Plan:
- Reset with INIT_LEVEL = 0, then valid codes 3000, 3000, 3000 on cycles 1-3 -> dout rises at the cycle-3 edge; rise_pulse is high one cycle; evt_valid = 1 with evt_pol = 1 and evt_ts = 3.
- From HI_STABLE, codes 1000, 1000, 2000 (BAND), 1000, 1000, 1000 -> no transition after the BAND sample (cnt reset); dout falls only after the final three; fall_pulse fires once.
- Codes oscillating between 1700 and 2400 (all BAND) for 50 cycles -> dout, the pulses and evt_valid stay at 0.
- QH, QH, sample_valid = 0 for 10 cycles, then QH -> commit occurs on the third valid sample (invalid cycles hold cnt).
- Hold evt_ready = 0 and produce 5 transitions -> first 4 events are queued and evt_ovf = 1. Then set evt_ready = 1 -> 4 pops with polarities 1, 0, 1, 0 and increasing timestamps; evt_valid drops to 0 afterwards.
- Assert rst while in HI_ARM with FIFO count 2 -> immediately dout = INIT_LEVEL, evt_valid = 0, evt_ovf = 0, timestamp = 0; the next event's evt_ts is counted from release of reset.
